// File: rtl/ps_shift_sequencer.sv
// ps_shift_sequencer: parallel-load / serial-shift word transfer controller.
// A word is accepted over a valid/ready handshake, shifted out MSB-first one bit
// per bit-tick while ser_in is captured into the vacated LSB, and the received
// word is presented with a one-cycle out_valid strobe (during the DONE state).
// Optional feature macro: PS_SEQ_PARITY_EN appends a parity bit tick and
// reports a receive parity mismatch on o_out_err.
//
// state   | meaning
// S_IDLE  | waiting for a word, in_ready high
// S_SHIFT | bit-ticks every DIV cycles, shifting out / in
// S_DONE  | received word valid for one cycle, then back to idle
module ps_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_ser_out,
    input  logic             i_ser_in,
    output logic             o_shift_en,
    output logic             o_busy,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_err
);

`ifdef PS_SEQ_PARITY_EN
    localparam int NTICK = WIDTH + 1;
`else
    localparam int NTICK = WIDTH;
`endif
    localparam int CW = $clog2(NTICK + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_TC  = DW'(DIV - 1);
    localparam logic [CW-1:0] LAST_BC = CW'(NTICK - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic [DW-1:0]    r_divcnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_tick;
    logic             w_last;
    logic [WIDTH-1:0] w_rx_word;

    assign w_tick    = (r_state == S_SHIFT) && (r_divcnt == DIV_TC);
    assign w_last    = (r_bitcnt == LAST_BC);
    assign w_rx_word = {r_shreg[WIDTH-2:0], i_ser_in};

`ifdef PS_SEQ_PARITY_EN
    logic r_par;
    logic r_out_err;
    logic w_par_tick;

    // the parity bit tick follows the last data bit; it is sent but never shifted in
    assign w_par_tick = (r_bitcnt == CW'(WIDTH));

    // tx parity capture at accept and rx parity check on the parity tick
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_par     <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_in_valid)
                r_par <= ^i_in_data;
            if (w_tick && w_par_tick)
                r_out_err <= i_ser_in ^ (^r_shreg);
        end
    end

    assign o_ser_out = (r_state == S_SHIFT) ? (w_par_tick ? r_par : r_shreg[WIDTH-1]) : 1'b0;
    assign o_out_err = r_out_err;
`else
    assign o_ser_out = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
    assign o_out_err = 1'b0;
`endif

    // main sequencer: handshake, bit-tick divider, shift register and result capture
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_bitcnt    <= '0;
            r_divcnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_out_valid <= 1'b0;
                    if (i_in_valid) begin
                        r_shreg  <= i_in_data;
                        r_bitcnt <= '0;
                        r_divcnt <= '0;
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_divcnt <= '0;
                        r_bitcnt <= r_bitcnt + CW'(1);
`ifdef PS_SEQ_PARITY_EN
                        if (!w_par_tick)
                            r_shreg <= w_rx_word;
                        if (w_last) begin
                            r_out_data  <= r_shreg;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
`else
                        r_shreg <= w_rx_word;
                        if (w_last) begin
                            r_out_data  <= w_rx_word;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
`endif
                    end else begin
                        r_divcnt <= r_divcnt + DW'(1);
                    end
                end
                S_DONE: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_shift_en  = w_tick;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_ps_shift_sequencer.sv
// Directed bench for ps_shift_sequencer: four instances with DIV = 1, 3, 2, 5.
// Instances 0 and 1 run directed vectors; 0, 2, 3 also run loopback words.
module tb_ps_shift_sequencer;
    localparam int W = 4;
`ifdef PS_SEQ_PARITY_EN
    localparam int NT = W + 1;
`else
    localparam int NT = W;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         vld  [4];
    logic [W-1:0] din  [4];
    logic         sdrv [4];
    logic         lb   [4];
    logic         inv  [4];
    logic         sin  [4];
    logic         rdy  [4];
    logic         so   [4];
    logic         se   [4];
    logic         bsy  [4];
    logic         ov   [4];
    logic         oerr [4];
    logic [W-1:0] dout [4];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 5;
        assign sin[g] = lb[g] ? (so[g] ^ inv[g]) : sdrv[g];
        ps_shift_sequencer #(.WIDTH(W), .DIV(D)) u_dut (
            .i_clk      (clk),
            .i_reset    (rst),
            .i_in_valid (vld[g]),
            .i_in_data  (din[g]),
            .o_in_ready (rdy[g]),
            .o_ser_out  (so[g]),
            .i_ser_in   (sin[g]),
            .o_shift_en (se[g]),
            .o_busy     (bsy[g]),
            .o_out_valid(ov[g]),
            .o_out_data (dout[g]),
            .o_out_err  (oerr[g])
        );
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one directed transfer; rx is the word driven back on ser_in, MSB first
    task automatic xfer(input int g, input int div, input logic [W-1:0] data, input logic [W-1:0] rx);
        logic [W:0] txb;
        logic [W:0] rxb;
        int k;
        txb = {data, ^data};
        rxb = {rx, ^rx};
        @(negedge clk);
        vld[g] = 1'b1;
        din[g] = data;
        for (int n = 1; n <= NT*div + 2; n++) begin
            @(negedge clk);
            if (n == 1) vld[g] = 1'b0;
            if (n <= NT*div) begin
                chk1("shift_en", se[g], (n % div) == 0);
                chk1("busy", bsy[g], 1'b1);
                chk1("no_early_valid", ov[g], 1'b0);
                if ((n % div) == 0) begin
                    k = n / div;
                    chk1("ser_out", so[g], txb[W+1-k]);
                    sdrv[g] = rxb[W+1-k];
                end
            end else if (n == NT*div + 1) begin
                chk1("out_valid", ov[g], 1'b1);
                chkw("out_data", dout[g], rx);
                chk1("out_err", oerr[g], 1'b0);
                chk1("in_ready_done", rdy[g], 1'b0);
                chk1("ser_out_done", so[g], 1'b0);
                chk1("shift_en_done", se[g], 1'b0);
            end else begin
                chk1("out_valid_clear", ov[g], 1'b0);
                chk1("in_ready_return", rdy[g], 1'b1);
                chkw("out_data_hold", dout[g], rx);
            end
        end
    endtask

    // loopback: 100 random words, each must come back intact with exact latency
    task automatic lb_run(input int g, input int div);
        logic [W-1:0] d;
        int cnt;
        lb[g] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            d = W'($urandom);
            @(negedge clk);
            vld[g] = 1'b1;
            din[g] = d;
            @(negedge clk);
            vld[g] = 1'b0;
            cnt = 1;
            while (ov[g] !== 1'b1 && cnt < NT*div + 4) begin
                @(negedge clk);
                cnt++;
            end
            chk1("lb_valid_seen", ov[g], 1'b1);
            chk1("lb_latency", cnt == NT*div + 1, 1'b1);
            chkw("lb_data", dout[g], d);
            chk1("lb_err", oerr[g], 1'b0);
            @(negedge clk);
            chk1("lb_single_valid", ov[g], 1'b0);
        end
        lb[g] = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] txb5;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 1'b0; din[i] = '0; sdrv[i] = 1'b0; lb[i] = 1'b0; inv[i] = 1'b0;
        end
        rst = 1'b1;

        // reset state
        @(negedge clk);
        chk1("rst_in_ready", rdy[0], 1'b1);
        chk1("rst_busy", bsy[0], 1'b0);
        chk1("rst_ser_out", so[0], 1'b0);
        chk1("rst_shift_en", se[0], 1'b0);
        chk1("rst_out_valid", ov[0], 1'b0);
        chkw("rst_out_data", dout[0], 4'h0);
        chk1("rst_out_err", oerr[0], 1'b0);
        rst = 1'b0;

        // DIV=1: tx 1011, rx 0101
        xfer(0, 1, 4'b1011, 4'b0101);
        // DIV=3: tx 1100, rx 0110
        xfer(1, 3, 4'b1100, 4'b0110);

        // in_valid held high: A accepted, 5 not accepted until NT+2 cycles later
        sdrv[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b1;
        din[0] = 4'hA;
        for (int n = 1; n <= NT + 1; n++) begin
            @(negedge clk);
            if (n == 1) din[0] = 4'h5;
            chk1("hold_in_ready_low", rdy[0], 1'b0);
            if (n == NT + 1) begin
                chk1("hold_valid_a", ov[0], 1'b1);
                chkw("hold_data_a", dout[0], 4'hF);
            end
        end
        @(negedge clk);
        chk1("hold_in_ready_idle", rdy[0], 1'b1);
        chk1("hold_valid_clear", ov[0], 1'b0);
        txb5 = {4'h5, ^4'h5};
        for (int k = 1; k <= NT; k++) begin
            @(negedge clk);
            if (k == 1) vld[0] = 1'b0;
            chk1("hold_shift_en_5", se[0], 1'b1);
            chk1("hold_ser_out_5", so[0], txb5[W+1-k]);
        end
        @(negedge clk);
        chk1("hold_valid_5", ov[0], 1'b1);
        chkw("hold_data_5", dout[0], 4'hF);

        // reset after two ticks of a transfer
        sdrv[0] = 1'b0;
        @(negedge clk);
        vld[0] = 1'b1;
        din[0] = 4'h9;
        @(negedge clk);
        vld[0] = 1'b0;
        chk1("abort_tick1", se[0], 1'b1);
        @(negedge clk);
        chk1("abort_tick2", se[0], 1'b1);
        rst = 1'b1;
        #1;
        chk1("abort_in_ready", rdy[0], 1'b1);
        chk1("abort_busy", bsy[0], 1'b0);
        chk1("abort_ser_out", so[0], 1'b0);
        chk1("abort_shift_en", se[0], 1'b0);
        chk1("abort_out_valid", ov[0], 1'b0);
        chkw("abort_out_data", dout[0], 4'h0);
        chk1("abort_out_err", oerr[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk1("abort_no_valid", ov[0], 1'b0);
            chk1("abort_stays_idle", rdy[0], 1'b1);
        end
        xfer(0, 1, 4'h6, 4'h6);

`ifdef PS_SEQ_PARITY_EN
        // parity tick in loopback, then with the parity bit inverted on the way back
        for (int t = 0; t < 2; t++) begin
            lb[0] = 1'b1;
            @(negedge clk);
            vld[0] = 1'b1;
            din[0] = 4'b1011;
            for (int n = 1; n <= NT + 1; n++) begin
                @(negedge clk);
                if (n == 1) vld[0] = 1'b0;
                if (n == NT) begin
                    chk1("par_ser_out", so[0], 1'b1);
                    chk1("par_shift_en", se[0], 1'b1);
                    if (t == 1) inv[0] = 1'b1;
                end
                if (n == NT + 1) begin
                    inv[0] = 1'b0;
                    chk1("par_valid", ov[0], 1'b1);
                    chkw("par_data", dout[0], 4'b1011);
                    chk1("par_err", oerr[0], t == 1);
                end
            end
            lb[0] = 1'b0;
        end
`endif

        lb_run(0, 1);
        lb_run(2, 2);
        lb_run(3, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
